fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Parametrised successor to the 4-bit processor's fetch path. It combines the program counter, instruction/operand fetch registers and fetch/execute phase toggle in one block, and adds a hardware return-address stack for CALL/RET.
- Sits between the decoder (which supplies PC commands) and the program ROM (which supplies program_byte).
- Lets wider instruction and address formats reuse one block.

Parameters:
ADDR_W, 12, program counter / ROM address width
INSTR_W, 4, opcode field width (upper bits of program_byte)
OPRND_W, 4, operand field width (lower bits of program_byte)
STACK_DEPTH, 4, return-address stack entries (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
ena  input  1  global enable; when low all state holds
load_pc  input  1  load PC from jump_addr
inc_pc  input  1  increment PC
call  input  1  push PC+1, load PC from jump_addr
ret  input  1  pop stack into PC
jump_addr  input  ADDR_W  branch/call target
program_byte  input  INSTR_W+OPRND_W  ROM data at current PC
pc  output  ADDR_W  program counter (ROM address)
instr  output  INSTR_W  latched opcode
oprnd  output  OPRND_W  latched operand
phase  output  1  0 = fetch, 1 = execute
stack_empty  output  1  stack holds 0 entries
stack_full  output  1  stack holds STACK_DEPTH entries
stack_err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (clk edge with reset=1, regardless of ena):
  - pc=0, instr=0, oprnd=0, phase=0.
  - Stack pointer=0, so stack_empty=1 and stack_full=0.
  - stack_err=0.
  - Reset mid-operation discards stack contents and any pending command.
- ena=0 with reset=0: every register holds; command inputs are ignored.
- Phase: toggles on every enabled edge. A two-state FSM, FETCH(0) <-> EXECUTE(1).
- Fetch latch:
  - On an enabled edge with phase=0, instr <= program_byte[INSTR_W+OPRND_W-1:OPRND_W] and oprnd <= program_byte[OPRND_W-1:0].
  - Both hold when phase=1.
  - Latency: program_byte visible on instr/oprnd 1 cycle after the fetch edge.
- PC commands:
  - Evaluated on every enabled edge in either phase; the decoder owns timing.
  - Priority: ret > call > load_pc > inc_pc. Exactly one action per edge; lower-priority inputs are ignored.
  - ret, stack non-empty: pc <= top entry; pointer decrements.
  - ret, stack empty: underflow. pc <= pc+1, stack_err <= 1, pointer unchanged.
  - call, stack not full: push (pc+1) mod 2^ADDR_W; pc <= jump_addr.
  - call, stack full: overflow. pc <= jump_addr, push dropped, contents and pointer unchanged, stack_err <= 1.
  - load_pc: pc <= jump_addr.
  - inc_pc: pc <= (pc+1) mod 2^ADDR_W, so 2^ADDR_W-1 wraps to 0.
  - None asserted: pc holds.
- call and ret in the same cycle: ret executes; call is ignored with no push and no error.
- stack_err clears only on reset.
- stack_empty and stack_full are combinational from the pointer (0..STACK_DEPTH).
- LIFO order: the most recent push is popped first. Entries beyond the pointer are don't-care.
- Arithmetic: all PC math is unsigned modulo 2^ADDR_W; no carry out.

Test Plan:
- Reset/phase:
  - Stimulus: reset=1 for 2 edges, then ena=1, program_byte=8'hA5.
  - Response: pc=0, phase=0, stack_empty=1 after reset.
  - Response: after the first enabled edge, instr=4'hA, oprnd=4'h5, phase=1.
  - Response: after the second edge, instr/oprnd still A/5 with program_byte=8'h3C, phase=0.
- Increment/wrap/enable:
  - Stimulus: load_pc with jump_addr=12'hFFE, then inc_pc for 3 edges.
  - Response: pc sequence FFE, FFF, 000, 001.
  - Stimulus: repeat with ena=0 for 2 edges.
  - Response: pc and phase frozen.
- Nested call/ret:
  - Stimulus: at pc=12'h010, call jump_addr=12'h100; at 12'h100, call jump_addr=12'h200; then ret, ret.
  - Response: pc goes 100, 200, 101, 011.
  - Response: stack_empty=1 at the end, stack_err=0.
- Overflow:
  - Stimulus: 5 consecutive calls (STACK_DEPTH=4) from pc=0 to targets 1, 2, 3, 4, 5.
  - Response: stack_full=1 after the 4th call; the 5th gives pc=5 and stack_err=1.
  - Response: 4 rets give pc 4, 3, 2, 1.
- Underflow and priority:
  - Stimulus: ret on an empty stack at pc=12'h020.
  - Response: pc=021, stack_err=1.
  - Stimulus: call+ret+load_pc+inc_pc asserted together with one entry 12'h050 on the stack.
  - Response: pc=050, no push, stack_empty=1.
- Reset mid-operation:
  - Stimulus: 2 calls, then reset=1 on an edge with ena=0.
  - Response: pc=0, stack_empty=1, stack_err=0, phase=0.
  - Response: a following ret flags underflow (stack_err=1).

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: program counter, opcode/operand fetch latch, fetch/execute
// phase toggle and a small return-address stack for CALL/RET.
module fetch_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int INSTR_W     = 4,
    parameter int OPRND_W     = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ena,
    input  logic                       load_pc,
    input  logic                       inc_pc,
    input  logic                       call,
    input  logic                       ret,
    input  logic [ADDR_W-1:0]          jump_addr,
    input  logic [INSTR_W+OPRND_W-1:0] program_byte,
    output logic [ADDR_W-1:0]          pc,
    output logic [INSTR_W-1:0]         instr,
    output logic [OPRND_W-1:0]         oprnd,
    output logic                       phase,
    output logic                       stack_empty,
    output logic                       stack_full,
    output logic                       stack_err
);

    // Pointer counts entries 0..STACK_DEPTH, so it needs one more code than the index.
    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(STACK_DEPTH);

    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } phase_t;

    phase_t            phaseState;
    logic [PTR_W-1:0]  sp;
    logic [PTR_W-1:0]  spDec;
    logic [ADDR_W-1:0] retStack [STACK_DEPTH];
    logic [ADDR_W-1:0] pcInc;
    logic [IDX_W-1:0]  pushIdx;
    logic [IDX_W-1:0]  popIdx;
    logic              isEmpty;
    logic              isFull;
    logic              doPush;

    assign pcInc   = pc + ADDR_W'(1);
    assign spDec   = sp - PTR_W'(1);
    assign pushIdx = sp[IDX_W-1:0];
    assign popIdx  = spDec[IDX_W-1:0];
    assign isEmpty = (sp == '0);
    assign isFull  = (sp == FULL_CNT);

    // A push happens only for a call that wins priority (no ret) and has room.
    assign doPush = ena && !reset && call && !ret && !isFull;

    assign phase       = phaseState;
    assign stack_empty = isEmpty;
    assign stack_full  = isFull;

    // Stack storage; contents need no reset since entries above the pointer are dead.
    always_ff @(posedge clk) begin
        if (doPush)
            retStack[pushIdx] <= pcInc;
    end

    // Phase FSM, fetch latch, PC command decode and stack pointer/error tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            phaseState <= FETCH;
            pc         <= '0;
            instr      <= '0;
            oprnd      <= '0;
            sp         <= '0;
            stack_err  <= 1'b0;
        end else if (ena) begin
            case (phaseState)
                FETCH: begin
                    instr      <= program_byte[INSTR_W+OPRND_W-1:OPRND_W];
                    oprnd      <= program_byte[OPRND_W-1:0];
                    phaseState <= EXECUTE;
                end
                default: phaseState <= FETCH;
            endcase

            // ret > call > load_pc > inc_pc; exactly one action per edge.
            if (ret) begin
                if (isEmpty) begin
                    pc        <= pcInc;
                    stack_err <= 1'b1;
                end else begin
                    pc <= retStack[popIdx];
                    sp <= spDec;
                end
            end else if (call) begin
                pc <= jump_addr;
                if (isFull)
                    stack_err <= 1'b1;
                else
                    sp <= sp + PTR_W'(1);
            end else if (load_pc) begin
                pc <= jump_addr;
            end else if (inc_pc) begin
                pc <= pcInc;
            end
        end
    end

endmodule
